seq_square: RTL and testbench

- Sequential integer squarer, the inverse of the square-root block: computes dt_o = dt_i * dt_i with a radix-2 shift-add loop.
- Sits beside the square-root block in the arithmetic-challenge datapath; doubles as a golden round-trip source (square then root) for that block.
- Start/busy/done handshake; enb_i is a global clock-enable that freezes all state.

---
 rtl/seq_square_pkg.sv | 28 ++
 rtl/seq_square_if.sv | 35 +++
 rtl/seq_square.sv | 92 +++++++++
 tb/tb_seq_square.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_square_pkg.sv
// Shared types and constants for the sequential squarer.
// Contents:
//   sqr_state_t    - FSM state encoding (IDLE, CALC, DONE)
//   SQR_WIDTH_DEF  - default operand width
//   sqr_cnt_width  - width of the step counter for a given operand width
package sqr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqr_state_t;

  localparam int SQR_WIDTH_DEF = 8;

  // Counter must hold 0..WIDTH-1; never let it collapse to zero bits.
  function automatic int sqr_cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_square_if.sv
// Start/busy/done handshake bundle for the sequential squarer.
// Signals:
//   start_i  request from the master, sampled by the squarer while idle
//   dt_i     WIDTH-bit unsigned operand
//   dt_o     2*WIDTH-bit unsigned square
//   busy_o   operation in progress
//   done_o   one-enabled-cycle completion pulse
// Modports: master (requester side), slave (squarer side).
interface seq_square_if
  import sqr_pkg::*;
#(
  parameter int WIDTH = SQR_WIDTH_DEF
);
  logic                 start_i;
  logic [WIDTH-1:0]     dt_i;
  logic [2*WIDTH-1:0]   dt_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i,
    output dt_i,
    input  dt_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  dt_i,
    output dt_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/seq_square.sv
// Sequential integer squarer: dt_o = dt_i * dt_i using a radix-2 shift-add
// loop, one multiplier bit per enabled clock.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset, wins over enb_i
//   enb_i  global clock enable; 0 freezes every register
//   bus    slave side of seq_square_if (start_i, dt_i, dt_o, busy_o, done_o)
// Latency: WIDTH+1 enabled edges from the accepting edge to done_o/dt_o.
module seq_square
  import sqr_pkg::*;
#(
  parameter int WIDTH = SQR_WIDTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enb_i,
  seq_square_if.slave  bus
);

  localparam int CW = sqr_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  sqr_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_dt_o;
  logic                 r_done;

  // FSM plus shift-add datapath; everything holds while enb_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_dt_o   <= '0;
      r_done   <= 1'b0;
    end else if (enb_i) begin
      case (r_state)
        IDLE: begin
          // Clearing here ends the done pulse; a start on the same edge is
          // still accepted, which gives back-to-back operation.
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.dt_i};
            r_mplier <= bus.dt_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= CALC;
          end else begin
            r_state  <= IDLE;
          end
        end
        CALC: begin
          r_done <= 1'b0;
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end else begin
            r_acc <= r_acc;
          end
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= DONE;
          end else begin
            r_state <= CALC;
          end
        end
        DONE: begin
          r_dt_o  <= r_acc;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  assign bus.dt_o   = r_dt_o;
  assign bus.done_o = r_done;
  assign bus.busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_seq_square.sv
// Directed self-checking bench for seq_square (WIDTH = 8).
module tb_seq_square;
  import sqr_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  logic enb;
  int   n_checks;
  int   n_fail;

  seq_square_if #(.WIDTH(W)) bus_if ();

  seq_square #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .enb_i (enb),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an operation (caller sits at a negedge) and count enabled edges
  // from the accepting edge until done_o is seen; bounded at 40 edges.
  task automatic run_op(input logic [W-1:0] d, output int lat,
                        output logic [2*W-1:0] res, output bit tmo);
    bus_if.start_i = 1'b1;
    bus_if.dt_i    = d;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    lat = 0;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_if.done_o === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
    res = bus_if.dt_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enb = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.dt_i    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus_if.dt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_dt_o got %0d want 0", bus_if.dt_o);
    end
    n_checks++;
    if (bus_if.done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b want 0", bus_if.done_o);
    end
    n_checks++;
    if (bus_if.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", bus_if.busy_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b want 0/0",
                         bus_if.busy_o, bus_if.done_o);
    end
  endtask

  task automatic test_single;
    logic [W-1:0]   ops [3];
    logic [2*W-1:0] exp [3];
    int lat;
    logic [2*W-1:0] res;
    bit tmo;
    ops[0] = 8'd15;  exp[0] = 16'd225;
    ops[1] = 8'd255; exp[1] = 16'd65025;
    ops[2] = 8'd0;   exp[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      // busy must rise right after the accepting edge
      bus_if.start_i = 1'b1;
      bus_if.dt_i    = ops[i];
      @(posedge clk);
      @(negedge clk);
      bus_if.start_i = 1'b0;
      n_checks++;
      if (bus_if.busy_o !== 1'b1) begin
        n_fail++; $display("FAIL single_busy op=%0d got %b want 1", ops[i], bus_if.busy_o);
      end
      lat = 0;
      tmo = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (bus_if.done_o === 1'b1) begin
          tmo = 1'b0;
          break;
        end
      end
      res = bus_if.dt_o;
      n_checks++;
      if (tmo || lat != 9) begin
        n_fail++; $display("FAIL single_latency op=%0d got %0d (timeout=%b) want 9", ops[i], lat, tmo);
      end
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++; $display("FAIL single_result op=%0d got %0d want %0d", ops[i], res, exp[i]);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
        n_fail++; $display("FAIL single_pulse op=%0d got done=%b busy=%b want 0/0",
                           ops[i], bus_if.done_o, bus_if.busy_o);
      end
    end
  endtask

  task automatic test_sweep;
    int lat;
    logic [2*W-1:0] res;
    logic [2*W-1:0] exp;
    bit tmo;
    for (int j = 0; j < 256; j++) begin
      exp = 16'(j * j);
      run_op(8'(j), lat, res, tmo);
      n_checks++;
      if (tmo || lat != 9 || res !== exp) begin
        n_fail++; $display("FAIL sweep j=%0d got %0d lat=%0d tmo=%b want %0d lat=9",
                           j, res, lat, tmo, exp);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus_if.dt_o !== exp || bus_if.done_o !== 1'b0) begin
        n_fail++; $display("FAIL sweep_hold j=%0d got %0d done=%b want %0d done=0",
                           j, bus_if.dt_o, bus_if.done_o, exp);
      end
    end
  endtask

  task automatic test_enable_freeze(input logic [2*W-1:0] prev);
    int lat;
    bit tmo;
    bus_if.start_i = 1'b1;
    bus_if.dt_i    = 8'd200;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    enb = 1'b0;
    repeat (5) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      n_checks++;
      if (bus_if.busy_o !== 1'b1 || bus_if.done_o !== 1'b0 || bus_if.dt_o !== prev) begin
        n_fail++; $display("FAIL freeze_outputs got busy=%b done=%b dt_o=%0d want 1/0/%0d",
                           bus_if.busy_o, bus_if.done_o, bus_if.dt_o, prev);
      end
    end
    enb = 1'b1;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_if.done_o === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
    n_checks++;
    if (tmo || lat != 14) begin
      n_fail++; $display("FAIL freeze_latency got %0d (timeout=%b) want 14", lat, tmo);
    end
    n_checks++;
    if (bus_if.dt_o !== 16'd40000) begin
      n_fail++; $display("FAIL freeze_result got %0d want 40000", bus_if.dt_o);
    end
    // done must hold across a disabled edge
    enb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_if.done_o !== 1'b1) begin
      n_fail++; $display("FAIL freeze_done_hold got %b want 1", bus_if.done_o);
    end
    enb = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    int dones;
    bit tmo;
    bus_if.start_i = 1'b1;
    bus_if.dt_i    = 8'd10;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    lat = 1;
    dones = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    // start held with a new operand through the rest of the operation
    bus_if.start_i = 1'b1;
    bus_if.dt_i    = 8'd3;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.done_o === 1'b1) begin
        dones++;
        tmo = 1'b0;
        break;
      end
    end
    n_checks++;
    if (tmo || bus_if.dt_o !== 16'd100) begin
      n_fail++; $display("FAIL collision_result got %0d (timeout=%b) want 100", bus_if.dt_o, tmo);
    end
    // this edge clears done and accepts the held start
    @(posedge clk);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    n_checks++;
    if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1",
                         bus_if.done_o, bus_if.busy_o);
    end
    lat = 0;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_if.done_o === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
    n_checks++;
    if (tmo || lat != 9 || bus_if.dt_o !== 16'd9 || dones != 1) begin
      n_fail++; $display("FAIL b2b_result got %0d lat=%0d dones=%0d want 9 lat=9 dones=1",
                         bus_if.dt_o, lat, dones);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int lat;
    logic [2*W-1:0] res;
    bit tmo;
    bit saw_done;
    bus_if.start_i = 1'b1;
    bus_if.dt_i    = 8'd100;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus_if.busy_o !== 1'b0 || bus_if.dt_o !== 16'd0 || bus_if.done_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got busy=%b dt_o=%0d done=%b want 0/0/0",
                         bus_if.busy_o, bus_if.dt_o, bus_if.done_o);
    end
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.done_o === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL midrst_no_done got pulse want none");
    end
    run_op(8'd7, lat, res, tmo);
    n_checks++;
    if (tmo || lat != 9 || res !== 16'd49) begin
      n_fail++; $display("FAIL midrst_next got %0d lat=%0d want 49 lat=9", res, lat);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_sweep();
    test_enable_freeze(16'd65025);
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
